// File: rtl/hazard_controller_if.sv
// hazard_controller_if: hazard inputs and pipeline control outputs of the hazard sequencer
interface hazard_controller_if #(parameter int CNT_W = 16);
   logic             ID_EX_MemRead;
   logic [4:0]       ID_EX_RegisterRt;
   logic [4:0]       IF_ID_RegisterRs;
   logic [4:0]       IF_ID_RegisterRt;
   logic             ID_EX_MdStart;
   logic             Branch_Taken;
   logic             PCWrite;
   logic             IF_ID_Write;
   logic             ID_EX_Write;
   logic             ID_EX_Bubble;
   logic             EX_MEM_Bubble;
   logic             IF_ID_Flush;
   logic             MdBusy;
   logic             MdDone;
   logic [CNT_W-1:0] StallCycles;
   logic [CNT_W-1:0] FlushCount;
   modport master (
      output ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt, ID_EX_MdStart, Branch_Taken,
      input  PCWrite, IF_ID_Write, ID_EX_Write, ID_EX_Bubble, EX_MEM_Bubble, IF_ID_Flush, MdBusy, MdDone,
             StallCycles, FlushCount
   );
   modport slave (
      input  ID_EX_MemRead, ID_EX_RegisterRt, IF_ID_RegisterRs, IF_ID_RegisterRt, ID_EX_MdStart, Branch_Taken,
      output PCWrite, IF_ID_Write, ID_EX_Write, ID_EX_Bubble, EX_MEM_Bubble, IF_ID_Flush, MdBusy, MdDone,
             StallCycles, FlushCount
   );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller: load-use / branch-flush / mult-div stall sequencer with saturating statistics
module hazard_controller #(
   parameter int MD_LATENCY = 4,
   parameter int CNT_W      = 16
) (
   input logic                clk,
   input logic                rst_n,
   hazard_controller_if.slave hif
);
   typedef enum logic {RUN, MD_WAIT} state_t;
   state_t           state_q, state_d;
   logic [7:0]       md_cnt_q, md_cnt_d;
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;
   logic             pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble, if_id_flush, md_busy, md_done;
   logic             load_use;
   assign load_use = hif.ID_EX_MemRead && hif.ID_EX_RegisterRt != 5'd0 &&
                     (hif.ID_EX_RegisterRt == hif.IF_ID_RegisterRs || hif.ID_EX_RegisterRt == hif.IF_ID_RegisterRt);
   // next state, same-cycle pipeline controls and saturating statistics
   always_comb begin
      state_d       = state_q;
      md_cnt_d      = md_cnt_q;
      flush_d       = flush_q;
      pc_write      = 1'b1;
      if_id_write   = 1'b1;
      id_ex_write   = 1'b1;
      id_ex_bubble  = 1'b0;
      ex_mem_bubble = 1'b0;
      if_id_flush   = 1'b0;
      md_busy       = 1'b0;
      md_done       = 1'b0;
      if (rst_n) begin
         if (state_q == MD_WAIT) begin
            if (md_cnt_q != 8'd0) begin
               {pc_write, if_id_write, id_ex_write} = 3'b000;
               ex_mem_bubble = 1'b1;
               md_busy       = 1'b1;
               md_cnt_d      = md_cnt_q - 8'd1;
            end else begin
               md_done = 1'b1;
               state_d = RUN;
            end
         end else if (hif.Branch_Taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            flush_d      = (flush_q != '1) ? flush_q + 1'b1 : flush_q;
         end else if (hif.ID_EX_MdStart) begin
            {pc_write, if_id_write, id_ex_write} = 3'b000;
            ex_mem_bubble = 1'b1;
            md_busy       = 1'b1;
            md_cnt_d      = 8'(MD_LATENCY - 2);
            state_d       = MD_WAIT;
         end else if (load_use) begin
            {pc_write, if_id_write} = 2'b00;
            id_ex_bubble = 1'b1;
         end
      end
      stall_d = (!pc_write && stall_q != '1) ? stall_q + 1'b1 : stall_q;
   end
   // state, mult/div down-counter and statistics registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= RUN;
         md_cnt_q <= 8'd0;
         stall_q  <= '0;
         flush_q  <= '0;
      end else begin
         state_q  <= state_d;
         md_cnt_q <= md_cnt_d;
         stall_q  <= stall_d;
         flush_q  <= flush_d;
      end
   end
   assign hif.PCWrite       = pc_write;
   assign hif.IF_ID_Write   = if_id_write;
   assign hif.ID_EX_Write   = id_ex_write;
   assign hif.ID_EX_Bubble  = id_ex_bubble;
   assign hif.EX_MEM_Bubble = ex_mem_bubble;
   assign hif.IF_ID_Flush   = if_id_flush;
   assign hif.MdBusy        = md_busy;
   assign hif.MdDone        = md_done;
   assign hif.StallCycles   = stall_q;
   assign hif.FlushCount    = flush_q;
endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller: directed and randomized checks of hazard_controller against a cycle-index model
module tb_hazard_controller;
   localparam int L    = 4;
   localparam int MAXC = 65535;
   localparam logic [7:0] DEF    = 8'b1110_0000;
   localparam logic [7:0] FREEZE = 8'b0000_1010;
   localparam logic [7:0] DONE   = 8'b1110_0001;
   localparam logic [7:0] BRANCH = 8'b1111_0100;
   localparam logic [7:0] LDUSE  = 8'b0011_0000;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int compared = 0;
   int mismatched = 0;
   int k = 0;
   int st = 0;
   int fl = 0;

   hazard_controller_if #(.CNT_W(16)) h1 ();
   hazard_controller_if #(.CNT_W(4))  h2 ();

   hazard_controller #(.MD_LATENCY(L), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .hif(h1));
   hazard_controller #(.MD_LATENCY(2), .CNT_W(4))  dut2 (.clk(clk), .rst_n(rst_n), .hif(h2));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ctl1();
      return {h1.PCWrite, h1.IF_ID_Write, h1.ID_EX_Write, h1.ID_EX_Bubble,
              h1.EX_MEM_Bubble, h1.IF_ID_Flush, h1.MdBusy, h1.MdDone};
   endfunction

   // expected controls: k is the 1-based EX cycle of an ongoing mult/div (0 = none)
   function automatic logic [7:0] model_ctl();
      logic lu;
      lu = h1.ID_EX_MemRead && h1.ID_EX_RegisterRt != 0 &&
           (h1.ID_EX_RegisterRt == h1.IF_ID_RegisterRs || h1.ID_EX_RegisterRt == h1.IF_ID_RegisterRt);
      if (!rst_n) return DEF;
      if (k > 0) return (k < L) ? FREEZE : DONE;
      if (h1.Branch_Taken) return BRANCH;
      if (h1.ID_EX_MdStart) return FREEZE;
      if (lu) return LDUSE;
      return DEF;
   endfunction

   task automatic step(input logic r, input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                       input logic [4:0] irt, input logic ms, input logic bt, input string tag);
      logic [7:0] e;
      rst_n = r;
      h1.ID_EX_MemRead = mr;
      h1.ID_EX_RegisterRt = rt;
      h1.IF_ID_RegisterRs = rs;
      h1.IF_ID_RegisterRt = irt;
      h1.ID_EX_MdStart = ms;
      h1.Branch_Taken = bt;
      #2;
      e = model_ctl();
      chk({tag, "_ctl"}, {8'd0, ctl1()}, {8'd0, e});
      @(posedge clk);
      if (!r) begin
         k = 0; st = 0; fl = 0;
      end else begin
         if (!e[7] && st < MAXC) st++;
         if (k == 0 && bt && fl < MAXC) fl++;
         k = (k == 0) ? ((ms && !bt) ? 2 : 0) : ((k == L) ? 0 : k + 1);
      end
      #1;
      chk({tag, "_stall"}, h1.StallCycles, 16'(st));
      chk({tag, "_flush"}, h1.FlushCount, 16'(fl));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      {h2.ID_EX_MemRead, h2.ID_EX_MdStart, h2.Branch_Taken} = 3'b000;
      h2.ID_EX_RegisterRt = 5'd3;
      h2.IF_ID_RegisterRs = 5'd3;
      h2.IF_ID_RegisterRt = 5'd0;
      @(posedge clk);
      #1;
      step(0, 1, 5, 5, 0, 1, 1, "reset");
      step(0, 0, 0, 0, 0, 0, 0, "reset2");
      chk("reset_stall_zero", h1.StallCycles, 16'd0);
      step(1, 1, 5, 5, 0, 0, 0, "loaduse");
      step(1, 0, 5, 5, 0, 0, 0, "after_loaduse");
      chk("loaduse_stall_one", h1.StallCycles, 16'd1);
      step(1, 1, 0, 0, 0, 0, 0, "rt_zero");
      step(1, 1, 7, 2, 7, 0, 0, "loaduse_rt");
      step(1, 1, 5, 5, 0, 0, 1, "branch_over_lu");
      chk("branch_flush_one", h1.FlushCount, 16'd1);
      chk("branch_stall_same", h1.StallCycles, 16'd2);
      for (int i = 0; i < L; i++) step(1, 0, 0, 0, 0, 1, 0, "md");
      step(1, 0, 0, 0, 0, 0, 0, "md_after");
      chk("md_stall", h1.StallCycles, 16'd5);
      step(1, 0, 0, 0, 0, 1, 0, "md2_a");
      step(1, 0, 0, 0, 0, 1, 0, "md2_b");
      step(0, 0, 0, 0, 0, 1, 0, "md2_rst");
      step(1, 0, 0, 0, 0, 0, 0, "post_rst");
      chk("post_rst_stall", h1.StallCycles, 16'd0);
      chk("post_rst_flush", h1.FlushCount, 16'd0);
      for (int i = 0; i < 300; i++) begin
         step(($urandom_range(0, 39) != 0), 1'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0), "rand");
      end
      step(0, 0, 0, 0, 0, 0, 0, "final_rst");
      rst_n = 1'b1;
      h2.ID_EX_MdStart = 1'b1;
      #2;
      chk("md2_c1", {13'd0, h2.PCWrite, h2.MdBusy, h2.MdDone}, 16'b010);
      tick();
      chk("md2_c2", {13'd0, h2.PCWrite, h2.MdBusy, h2.MdDone}, 16'b101);
      tick();
      h2.ID_EX_MdStart = 1'b0;
      #1;
      chk("md2_c3", {13'd0, h2.PCWrite, h2.MdBusy, h2.MdDone}, 16'b100);
      chk("md2_stall", {12'd0, h2.StallCycles}, 16'd1);
      h2.ID_EX_MemRead = 1'b1;
      for (int i = 0; i < 13; i++) tick();
      chk("sat_stall_14", {12'd0, h2.StallCycles}, 16'd14);
      tick();
      chk("sat_stall_15", {12'd0, h2.StallCycles}, 16'd15);
      tick();
      chk("sat_stall_hold", {12'd0, h2.StallCycles}, 16'd15);
      chk("sat_stall_pc", {15'd0, h2.PCWrite}, 16'd0);
      h2.ID_EX_MemRead = 1'b0;
      h2.Branch_Taken = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      chk("sat_flush_hold", {12'd0, h2.FlushCount}, 16'd15);
      chk("sat_stall_after", {12'd0, h2.StallCycles}, 16'd15);
      h2.Branch_Taken = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
